store_buffer: RTL and testbench

Posted-write buffer between the load/store unit and the data tightly-integrated memory (DTIM). It accepts byte-enabled stores already formatted by the LSU (replicated data plus 4-bit byte mask), queues them in a small in-order FIFO, and drains them to the single DTIM port in cycles the port is not needed by a load. Loads always get the DTIM port first. A load that overlaps a buffered store either stalls until that store drains or, when forwarding is compiled in, gets the buffered bytes merged into its result.

---
 rtl/store_buffer_pkg.sv | 15 +
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer_fwd.sv | 32 +++
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and widths for the store buffer between the LSU and the DTIM port.
package store_buffer_pkg;

  localparam int unsigned WADR_W = 30;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADR_W  = 32;

  typedef struct packed {
    logic [WADR_W-1:0] wadr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } stbuf_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// LSU and DTIM signals of the store buffer; master is the core/memory side, slave the buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              StValid;
  logic [ADR_W-1:0]  StAdr;
  logic [BE_W-1:0]   StByteEn;
  logic [DATA_W-1:0] StData;
  logic              StReady;
  logic              LdValid;
  logic [ADR_W-1:0]  LdAdr;
  logic              LdStall;
  logic [DATA_W-1:0] LdData;
  logic              Drain;
  logic              Empty;
  logic [ADR_W-1:0]  DtimAdr;
  logic [BE_W-1:0]   DtimWE;
  logic [DATA_W-1:0] DtimWD;
  logic [DATA_W-1:0] DtimRD;

  modport master (
    output StValid, StAdr, StByteEn, StData, LdValid, LdAdr, Drain, DtimRD,
    input  StReady, LdStall, LdData, Empty, DtimAdr, DtimWE, DtimWD
  );

  modport slave (
    input  StValid, StAdr, StByteEn, StData, LdValid, LdAdr, Drain, DtimRD,
    output StReady, LdStall, LdData, Empty, DtimAdr, DtimWE, DtimWD
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-first byte merge of buffered stores into load data (STORE_BUFFER_FWD_EN builds only).
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  stbuf_entry_t      entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [WADR_W-1:0] ld_wadr,
  input  logic [DATA_W-1:0] dtim_rd,
  output logic [DATA_W-1:0] ld_data
);

  stbuf_entry_t ent;

  // Walk oldest to youngest so the youngest writer of each lane wins.
  always_comb begin
    ld_data = dtim_rd;
    ent     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent = entries[head + PTR_W'(k)];
      if (((PTR_W+1)'(k) < count) && (ent.wadr == ld_wadr)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (ent.be[b]) ld_data[8*b +: 8] = ent.data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write buffer draining to the DTIM port when no load needs it.
// Define STORE_BUFFER_FWD_EN to forward buffered bytes to loads instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           reset_n,
  store_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  stbuf_entry_t      entries_q [DEPTH];
  stbuf_entry_t      entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, st_ready, push, pop, load_port, ld_stall;
  logic [DATA_W-1:0] ld_data;
  logic              unused_adr_lsbs;

  assign full            = (count_q == CNT_W'(DEPTH));
  assign empty           = (count_q == '0);
  assign st_ready        = ~full & ~(bus.Drain & ~empty);
  assign push            = bus.StValid & st_ready;
  assign unused_adr_lsbs = ^{bus.StAdr[1:0], bus.LdAdr[1:0]};

`ifdef STORE_BUFFER_FWD_EN
  assign ld_stall = 1'b0;

  store_buffer_fwd #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .ld_wadr (bus.LdAdr[ADR_W-1:2]),
    .dtim_rd (bus.DtimRD),
    .ld_data (ld_data)
  );
`else
  logic [DEPTH-1:0] ld_hit;

  // An entry is live when its distance from head is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit[i] = ({1'b0, PTR_W'(i) - head_q} < count_q)
                & (entries_q[i].wadr == bus.LdAdr[ADR_W-1:2])
                & (|entries_q[i].be);
    end
  end

  assign ld_stall = bus.LdValid & (|ld_hit);
  assign ld_data  = bus.DtimRD;
`endif

  // A stalled load gives up the port so the store it waits on can drain.
  assign load_port = bus.LdValid & ~ld_stall;
  assign pop       = ~load_port & ~empty;

  always_comb begin
    bus.DtimAdr = '0;
    bus.DtimWE  = '0;
    bus.DtimWD  = '0;
    if (load_port) begin
      bus.DtimAdr = {bus.LdAdr[ADR_W-1:2], 2'b00};
    end else if (pop) begin
      bus.DtimAdr = {entries_q[head_q].wadr, 2'b00};
      bus.DtimWE  = entries_q[head_q].be;
      bus.DtimWD  = entries_q[head_q].data;
    end
  end

  assign bus.StReady = st_ready;
  assign bus.Empty   = empty;
  assign bus.LdStall = ld_stall;
  assign bus.LdData  = ld_data;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (push) begin
      entries_d[tail_q].wadr = bus.StAdr[ADR_W-1:2];
      entries_d[tail_q].be   = bus.StByteEn;
      entries_d[tail_q].data = bus.StData;
      tail_d                 = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of pushed stores plus a table of load vectors.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int drains_seen = 0;
  stbuf_entry_t sb_q[$];

  typedef struct {
    logic        st_valid;
    logic [31:0] st_adr;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_adr;
    logic [31:0] dtim_rd;
    logic        exp_stall;
    logic [31:0] exp_ld_data;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    logic s = 1'b0;
    if (!FWD && bus.LdValid)
      foreach (sb_q[i]) if (sb_q[i].wadr == bus.LdAdr[31:2]) s = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_ld_data();
    logic [31:0] d = bus.DtimRD;
    if (FWD)
      foreach (sb_q[i])
        if (sb_q[i].wadr == bus.LdAdr[31:2])
          for (int b = 0; b < 4; b++)
            if (sb_q[i].be[b]) d[8*b +: 8] = sb_q[i].data[8*b +: 8];
    return d;
  endfunction

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la,
                       input logic [31:0] rd, input logic dr);
    bus.StValid = sv; bus.StAdr = sa; bus.StByteEn = sbe; bus.StData = sd;
    bus.LdValid = lv; bus.LdAdr = la; bus.DtimRD = rd; bus.Drain = dr;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Mid-cycle: compare every output against the model, then retire/accept stores.
  task automatic settle();
    logic stall, lport, pop, push, ready;
    stbuf_entry_t h, n;
    #4;
    stall = model_stall();
    lport = bus.LdValid && !stall;
    pop   = !lport && (sb_q.size() != 0);
    ready = (sb_q.size() < DEPTH) && !(bus.Drain && (sb_q.size() != 0));
    push  = bus.StValid && ready;
    chk("st_ready", 32'(bus.StReady), 32'(ready));
    chk("empty", 32'(bus.Empty), 32'(sb_q.size() == 0));
    chk("ld_stall", 32'(bus.LdStall), 32'(stall));
    if (bus.LdValid) chk("ld_data", bus.LdData, model_ld_data());
    if (pop) begin
      h = sb_q.pop_front();
      chk("drain_adr", bus.DtimAdr, {h.wadr, 2'b00});
      chk("drain_we", 32'(bus.DtimWE), 32'(h.be));
      chk("drain_wd", bus.DtimWD, h.data);
      drains_seen++;
    end else begin
      chk("dtim_we_nodrain", 32'(bus.DtimWE), 32'd0);
      chk("dtim_adr", bus.DtimAdr, lport ? {bus.LdAdr[31:2], 2'b00} : 32'd0);
    end
    if (push) begin
      n.wadr = bus.StAdr[31:2]; n.be = bus.StByteEn; n.data = bus.StData;
      sb_q.push_back(n);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic wait_empty(input string name);
    idle();
    for (int n = 0; n < 16; n++) begin
      if (sb_q.size() == 0 && bus.Empty) break;
      cycle();
    end
    chk(name, 32'(bus.Empty), 32'd1);
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                              input logic [31:0] sd, input logic lv, input logic [31:0] la,
                              input logic [31:0] rd, input logic es, input logic [31:0] ed);
    vec_t v;
    v.st_valid = sv; v.st_adr = sa; v.st_be = sbe; v.st_data = sd;
    v.ld_valid = lv; v.ld_adr = la; v.dtim_rd = rd; v.exp_stall = es; v.exp_ld_data = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    // Reset values
    reset_n = 1'b0;
    idle();
    bus.DtimRD = 32'h1234_5678;
    #2;
    chk("rst_st_ready", 32'(bus.StReady), 32'd1);
    chk("rst_empty", 32'(bus.Empty), 32'd1);
    chk("rst_ld_stall", 32'(bus.LdStall), 32'd0);
    chk("rst_dtim_we", 32'(bus.DtimWE), 32'd0);
    chk("rst_dtim_adr", bus.DtimAdr, 32'd0);
    chk("rst_dtim_wd", bus.DtimWD, 32'd0);
    chk("rst_ld_data", bus.LdData, 32'h1234_5678);
    @(negedge clk);
    reset_n = 1'b1;
    adv();

    // Single store drains the next cycle
    drive(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle();
    idle();
    settle();
    chk("sw_adr", bus.DtimAdr, 32'h100);
    chk("sw_we", 32'(bus.DtimWE), 32'hF);
    chk("sw_wd", bus.DtimWD, 32'hDEAD_BEEF);
    adv();
    settle();
    chk("sw_empty_after", 32'(bus.Empty), 32'd1);
    adv();

    // Loads starve draining; buffer fills, then drains in order
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h10 + 32'(4*k), 4'hF, 32'hA000_0000 + 32'(k), 1'b1, 32'h200, 32'h0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h80, 4'hF, 32'hBAD0_BAD0, 1'b1, 32'h200, 32'h0, 1'b0);
    settle();
    chk("full_st_ready", 32'(bus.StReady), 32'd0);
    chk("full_no_drain", 32'(bus.DtimWE), 32'd0);
    adv();
    idle();
    d0 = drains_seen;
    for (int k = 0; k < 4; k++) cycle();
    chk("four_drains", 32'(drains_seen - d0), 32'd4);
    wait_empty("fill_empty");

    // Load vectors: overlap stall vs forwarding
    vecs.push_back(mk(1, 32'h40,  4'hF, 32'h0101_0101, 1, 32'h800, 32'hCAFE_F00D, 0, 32'hCAFE_F00D));
    vecs.push_back(mk(1, 32'h44,  4'hF, 32'h0202_0202, 1, 32'h800, 32'hCAFE_F00D, 0, 32'hCAFE_F00D));
    vecs.push_back(mk(1, 32'h101, 4'h2, 32'hAAAA_AAAA, 1, 32'h800, 32'hCAFE_F00D, 0, 32'hCAFE_F00D));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h101, 32'h1122_3344, !FWD,
                        FWD ? 32'h1122_AA44 : 32'h1122_3344));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h101, 32'h1122_3344, 0,
                      FWD ? 32'h1122_AA44 : 32'h1122_3344));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h300, 4'h3, 32'h5555_5555, 1, 32'h800, 32'h0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h300, 4'h2, 32'h6666_6666, 1, 32'h800, 32'h0, 0, 32'h0));
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300, 32'h0, !FWD, FWD ? 32'h0000_6655 : 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300, 32'h0, 0, FWD ? 32'h0000_6655 : 32'h0));
    foreach (vecs[i]) begin
      drive(vecs[i].st_valid, vecs[i].st_adr, vecs[i].st_be, vecs[i].st_data,
            vecs[i].ld_valid, vecs[i].ld_adr, vecs[i].dtim_rd, 1'b0);
      settle();
      chk($sformatf("vec%0d_stall", i), 32'(bus.LdStall), 32'(vecs[i].exp_stall));
      if (vecs[i].ld_valid)
        chk($sformatf("vec%0d_ld_data", i), bus.LdData, vecs[i].exp_ld_data);
      adv();
    end
    wait_empty("vec_empty");

    // Fill, then push and pop together across the pointer wrap
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000 + 32'(4*k), 4'hF, 32'hC000_0000 + 32'(k), 1'b1, 32'h800, 32'h0, 1'b0);
      cycle();
    end
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 32'h2000 + 32'(4*k), 4'(k + 1), 32'hD000_0000 + 32'(k), 1'b0, 32'h0, 32'h0, 1'b0);
      settle();
      if (k > 0) begin
        chk($sformatf("wrap%0d_ready", k), 32'(bus.StReady), 32'd1);
        chk($sformatf("wrap%0d_not_empty", k), 32'(bus.Empty), 32'd0);
      end
      adv();
    end
    wait_empty("wrap_empty");

    // Fence blocks pushes until empty
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h3000 + 32'(4*k), 4'hF, 32'hE000_0000 + 32'(k), 1'b1, 32'h800, 32'h0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h3100, 4'hF, 32'hF00D_0001, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("drain%0d_ready", k), 32'(bus.StReady), (k == 2) ? 32'd1 : 32'd0);
      adv();
    end
    wait_empty("drain_empty");

    // Reset mid-drain discards everything without a clock edge
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h4000 + 32'(4*k), 4'hF, 32'h7000_0000 + 32'(k), 1'b1, 32'h800, 32'h0, 1'b0);
      cycle();
    end
    idle();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.Empty), 32'd1);
    chk("arst_dtim_we", 32'(bus.DtimWE), 32'd0);
    chk("arst_st_ready", 32'(bus.StReady), 32'd1);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    adv();
    cycle();
    chk("post_rst_empty", 32'(bus.Empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
